poly1305_ds: RTL and testbench
==============================

Name: poly1305_ds

Overview:
Parametrised digit-serial Poly1305 one-time authenticator core and successor to the serial poly1305 core. It computes acc = ((acc + block) * r) mod (2^130-5), processing DIGIT_W bits of r per cycle, and finalises tag = (acc mod p + s) mod 2^128. New over the serial core: DIGIT_W generality, internal r clamping, a separate key-load strobe, hardware padding of partial final blocks from a byte length, and a tag-valid pulse. It sits between the message/key framing logic and the AEAD tag compare.

Parameters:
DIGIT_W, 32, width of r digit multiplied per cycle; legal values 8, 16, 32, 64, 128 (elaboration error otherwise).
N_DIG, 128/DIGIT_W, derived; multiply cycles per block; not user-set.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
key_ld  in  1  load r and s; honoured only when rdy=1
r  in  128  raw (unclamped) r, little-endian integer
s  in  128  s, little-endian integer
ld  in  1  block strobe; honoured only when rdy=1
first  in  1  with ld: clear acc before absorbing this block
last  in  1  with ld: finalise after this block
len  in  5  with ld: valid bytes in m, 1..16; 0 or >16 means 16
m  in  128  block data, byte 0 in m[7:0]
rdy  out  1  idle and able to accept ld/key_ld
p  out  128  tag; holds until the next finalisation
tag_vld  out  1  one-cycle pulse when p is updated

Behaviour:
- One clock and one reset: clk, with reset synchronous and active-high. While reset is high: acc=0, r_reg=0, s_reg=0, p=0, tag_vld=0, rdy=0, state=IDLE. rdy=1 in the first cycle after reset falls.
- key_ld with rdy=1: r_reg <= r & 128'h0ffffffc0ffffffc0ffffffc0fffffff, and s_reg <= s. If key_ld and ld occur in the same cycle, the new key is used for that block. key_ld with rdy=0 is ignored.
- Block formation: L = clamped len. blk = (m with bytes >= L zeroed) + 2^(8L). L=16 sets bit 128.
- ld accepted (rdy=1, rising edge): h = (first ? 0 : acc) + blk, 131 bits. The first, last and len inputs are latched. rdy drops the next cycle. ld with rdy=0 is ignored with no side effects.
- States:
  - IDLE: ld goes to MUL.
  - MUL: N_DIG cycles, MSB digit of r first, Horner form: t <= fold((t << DIGIT_W) + h * r_digit). fold(x) = x[129:0] + 5*x[hi:130]. t is bounded < 2^131.
  - RED: 1 cycle, final fold so acc < 2^130. Goes to FIN if last, else IDLE.
  - FIN: 1 cycle. a = acc >= p ? acc - p : acc. Then p <= (a + s_reg)[127:0], tag_vld=1, acc <= 0, go to IDLE.
- Latency from the accepting edge to rdy=1: N_DIG+1 edges (non-last) or N_DIG+2 edges (last). tag_vld is coincident with the first rdy=1 cycle after a last block.
- Throughput: back-to-back ld is permitted in the first rdy=1 cycle.
- acc persists across blocks until first, a finalisation, or reset. ld without first right after reset or a finalisation uses acc=0.
- Reset mid-operation aborts the computation: no tag_vld, p returns to 0.
- r=0 is legal; the tag is then s for any message.

Decomposition:
- poly1305_pkg:
  - constant P130 = 2^130-5
  - CLAMP_MASK
  - state enum {IDLE, MUL, RED, FIN}
  - function pad_block(m, len)
  - function fold130
- One combinational sub-module poly1305_dmul(h[130:0], t[130:0], r_digit[DIGIT_W-1:0]) -> fold((t<<DIGIT_W) + h*r_digit). The top module holds the FSM, registers, and the digit counter.

Test Plan:
1. RFC 8439 vector, DIGIT_W=32:
   - Stimulus: key_ld with r=128'ha806d542fe52447f336d555778bed685, s=128'h1bf54941aff6bf4afdb20dfb8a800301. Then ld first=1 m=128'h6f462063696870617267_6f7470797243 len=16. Then m=128'h6f72472068637261_65736552206d7572 len=16. Then last=1 m=128'h7075 len=2.
   - Required: the internal acc after each block is 130'h2c88c77849d64ae9147ddeb88e69c83fc, 130'h2d8adaf23b0337fa7cccfb4ea344b30de, 130'h28d31b7caff946c77c8844335369d03a7. p=128'ha927010caf8b2bc2c6365130c11d06a8, tag_vld high for exactly 1 cycle.
2. Latency, DIGIT_W=32: rdy is low for 5 cycles after each non-last ld and 6 after the last ld. tag_vld is asserted in the cycle rdy rises.
3. Repeat vector 1 three times back-to-back with first=1 on each first block: the same tag each time, proving acc is cleared. p holds between runs.
4. Pulse ld and key_ld (different r) during MUL of block 2: both ignored, and the tag is still a927...06a8. len=0 and len=31 produce the same tag as len=16 on the same m.
5. Assert reset for 1 cycle in MUL of block 3: no tag_vld, p=0, rdy=0 during reset, rdy=1 after. Re-running vector 1 gives the correct tag.
6. Sweep DIGIT_W = 8, 16, 64, 128 on vector 1: identical tag. Non-last latencies are 17, 9, 3, 2 cycles (+1 for last).

Source files
------------

// File: rtl/poly1305_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the digit-serial Poly1305 core.
package poly1305_pkg;

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned ACC_W  = 130;
   localparam int unsigned H_W    = 131;
   localparam int unsigned WIDE_W = 264;

   localparam logic [ACC_W-1:0] P130       = '1 - ACC_W'(4);
   localparam logic [KEY_W-1:0] CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RED  = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Keep bytes below the clamped length and append the 2^(8L) pad bit.
   function automatic logic [H_W-1:0] pad_block(input logic [KEY_W-1:0] m, input logic [4:0] len);
      logic [4:0]       l;
      logic [KEY_W-1:0] mask;
      l    = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
      mask = '0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < l) mask[i*8 +: 8] = 8'hff;
      end
      return H_W'(m & mask) + (H_W'(1) << {l, 3'b000});
   endfunction

   // One partial reduction step using 2^130 == 5 (mod p).
   function automatic logic [WIDE_W-1:0] fold130(input logic [WIDE_W-1:0] x);
      return WIDE_W'(x[ACC_W-1:0]) + WIDE_W'(x[WIDE_W-1:ACC_W]) * WIDE_W'(5);
   endfunction

endpackage

// File: rtl/poly1305_dmul.sv
// One Horner step: fold((t << DIGIT_W) + h * r_digit), kept below 2^131.
module poly1305_dmul
   import poly1305_pkg::*;
#(
   parameter int unsigned DIGIT_W = 32
)(
   input  logic [H_W-1:0]     h,
   input  logic [H_W-1:0]     t,
   input  logic [DIGIT_W-1:0] r_digit,
   output logic [H_W-1:0]     t_nxt_c
);

   logic [WIDE_W-1:0] sum_c;

   // Two folds are needed when the digit is wide enough that one fold overshoots 2^131.
   always_comb begin
      sum_c   = (WIDE_W'(t) << DIGIT_W) + WIDE_W'(h) * WIDE_W'(r_digit);
      t_nxt_c = H_W'(fold130(fold130(sum_c)));
   end

endmodule

// File: rtl/poly1305_ds.sv
// Digit-serial Poly1305 authenticator: absorbs 16-byte blocks and emits the 128-bit tag.
module poly1305_ds
   import poly1305_pkg::*;
#(
   parameter int unsigned DIGIT_W = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             key_ld,
   input  logic [KEY_W-1:0] r,
   input  logic [KEY_W-1:0] s,
   input  logic             ld,
   input  logic             first,
   input  logic             last,
   input  logic [4:0]       len,
   input  logic [KEY_W-1:0] m,
   output logic             rdy,
   output logic [KEY_W-1:0] p,
   output logic             tag_vld
);

   localparam int unsigned N_DIG = KEY_W / DIGIT_W;
   localparam int unsigned CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   if (!(DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32 || DIGIT_W == 64 || DIGIT_W == 128)) begin : g_bad_digit_w
      $error("poly1305_ds: DIGIT_W must be 8, 16, 32, 64 or 128");
   end

   state_t             state, state_n;
   logic               rdy_n, tag_vld_n;
   logic [CNT_W-1:0]   cnt;
   logic [KEY_W-1:0]   r_reg, s_reg, r_sh, r_use_c;
   logic [H_W-1:0]     h_reg, t_reg, h_in_c, t_nxt_c;
   logic [ACC_W-1:0]   acc, a_c;
   logic               last_q;
   logic               accept_c;
   logic [DIGIT_W-1:0] digit_c;

   // A key loaded alongside a block applies to that block.
   always_comb begin
      accept_c = ld && rdy;
      r_use_c  = key_ld ? (r & CLAMP_MASK) : r_reg;
      h_in_c   = (first ? '0 : H_W'(acc)) + pad_block(m, len);
      digit_c  = r_sh[KEY_W-1 -: DIGIT_W];
      a_c      = (acc >= P130) ? (acc - P130) : acc;
   end

   poly1305_dmul #(.DIGIT_W(DIGIT_W)) u_dmul (
      .h       (h_reg),
      .t       (t_reg),
      .r_digit (digit_c),
      .t_nxt_c (t_nxt_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      rdy_n     = 1'b0;
      tag_vld_n = 1'b0;
      case (state)
         IDLE:    if (accept_c) state_n = MUL;
         MUL:     if (cnt == CNT_W'(N_DIG - 1)) state_n = RED;
         RED:     state_n = last_q ? FIN : IDLE;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
      rdy_n     = (state_n == IDLE);
      tag_vld_n = (state == FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdy     <= 1'b0;
         tag_vld <= 1'b0;
      end else begin
         rdy     <= rdy_n;
         tag_vld <= tag_vld_n;
      end
   end

   // Datapath: key registers, Horner accumulation, reduction and finalisation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg  <= '0;
         s_reg  <= '0;
         r_sh   <= '0;
         h_reg  <= '0;
         t_reg  <= '0;
         acc    <= '0;
         p      <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
      end else begin
         if (rdy && key_ld) begin
            r_reg <= r & CLAMP_MASK;
            s_reg <= s;
         end
         case (state)
            IDLE: begin
               if (accept_c) begin
                  h_reg  <= h_in_c;
                  t_reg  <= '0;
                  r_sh   <= r_use_c;
                  cnt    <= '0;
                  last_q <= last;
               end
            end
            MUL: begin
               t_reg <= t_nxt_c;
               r_sh  <= r_sh << DIGIT_W;
               cnt   <= cnt + 1'b1;
            end
            RED: acc <= ACC_W'(fold130(fold130(WIDE_W'(t_reg))));
            FIN: begin
               p   <= KEY_W'(H_W'(a_c) + H_W'(s_reg));
               acc <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_poly1305_ds.sv
// Randomized self-checking bench for poly1305_ds across all legal digit widths.
module tb_poly1305_ds;

   localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
   localparam logic [263:0] PMOD  = (264'(1) << 130) - 264'(5);
   localparam logic [127:0] R1    = 128'ha806d542fe52447f336d555778bed685;
   localparam logic [127:0] S1    = 128'h1bf54941aff6bf4afdb20dfb8a800301;
   localparam logic [127:0] M1    = 128'h6f4620636968706172676f7470797243;
   localparam logic [127:0] M2    = 128'h6f7247206863726165736552206d7572;
   localparam logic [127:0] M3    = 128'h7075;
   localparam logic [129:0] ACC1  = 130'h2c88c77849d64ae9147ddeb88e69c83fc;
   localparam logic [129:0] ACC2  = 130'h2d8adaf23b0337fa7cccfb4ea344b30de;
   localparam logic [127:0] TAG1  = 128'ha927010caf8b2bc2c6365130c11d06a8;

   logic         clk = 1'b0;
   logic         reset;
   logic [4:0]   key_ld_v, ld_v, rdy_v, tv_v;
   logic [127:0] r, s, m;
   logic         first, last;
   logic [4:0]   len;
   logic [127:0] p_v [5];

   int total, bad;

   logic [129:0] macc [5];
   logic [127:0] mr [5];
   logic [127:0] ms [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      poly1305_ds #(.DIGIT_W(8 << g)) u_dut (
         .clk     (clk),
         .reset   (reset),
         .key_ld  (key_ld_v[g]),
         .r       (r),
         .s       (s),
         .ld      (ld_v[g]),
         .first   (first),
         .last    (last),
         .len     (len),
         .m       (m),
         .rdy     (rdy_v[g]),
         .p       (p_v[g]),
         .tag_vld (tv_v[g])
      );
   end

   task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Message block as an integer: low L bytes of m plus 2^(8L).
   function automatic logic [263:0] mdl_blk(input logic [127:0] mm, input logic [4:0] ln);
      int             l;
      logic [263:0]   one;
      l   = (ln == 5'd0 || ln > 5'd16) ? 16 : int'(ln);
      one = 264'(1) << (8 * l);
      return (264'(mm) % one) + one;
   endfunction

   function automatic logic [129:0] mdl_step(input logic [129:0] a, input logic [263:0] blk,
                                             input logic [127:0] rr);
      logic [263:0] x;
      x = (264'(a) + blk) * 264'(rr);
      return 130'(x % PMOD);
   endfunction

   task automatic model_reset;
      for (int i = 0; i < 5; i++) begin
         macc[i] = '0;
         mr[i]   = '0;
         ms[i]   = '0;
      end
   endtask

   task automatic load_key(input int k, input logic [127:0] rr, input logic [127:0] ss);
      check("key_rdy", 264'(rdy_v[k]), 264'(1));
      r = rr;
      s = ss;
      key_ld_v[k] = 1'b1;
      tick;
      key_ld_v[k] = 1'b0;
      mr[k] = rr & CLAMP;
      ms[k] = ss;
   endtask

   // mode 0: plain block; 1: stray ld/key_ld mid-multiply; 2: reset mid-multiply.
   task automatic run_block(input int k, input logic f, input logic l, input logic [4:0] ln,
                            input logic [127:0] mm, input int mode, input logic kl);
      int           lat;
      int           exp_lat;
      logic [127:0] r_keep;
      logic [127:0] tag;
      check("ld_rdy", 264'(rdy_v[k]), 264'(1));
      if (kl) begin
         mr[k] = r & CLAMP;
         ms[k] = s;
      end
      first = f; last = l; len = ln; m = mm;
      ld_v[k] = 1'b1;
      key_ld_v[k] = kl;
      tick;
      ld_v[k] = 1'b0;
      key_ld_v[k] = 1'b0;
      first = 1'($urandom()); last = 1'($urandom()); len = 5'($urandom()); m = rand128();
      if (f) macc[k] = '0;
      macc[k] = mdl_step(macc[k], mdl_blk(mm, ln), mr[k]);
      exp_lat = 128 / (8 << k) + (l ? 2 : 1);
      r_keep  = r;
      lat     = 0;
      while (rdy_v[k] !== 1'b1 && lat < 64) begin
         lat++;
         if (tv_v[k] !== 1'b0) check("tv_while_busy", 264'(tv_v[k]), 264'(0));
         if (mode == 2 && lat == 2) begin
            reset = 1'b1;
            tick;
            check("rst_rdy", 264'(rdy_v[k]), 264'(0));
            check("rst_p", 264'(p_v[k]), 264'(0));
            check("rst_tv", 264'(tv_v[k]), 264'(0));
            reset = 1'b0;
            tick;
            check("post_rst_rdy", 264'(rdy_v[k]), 264'(1));
            check("post_rst_p", 264'(p_v[k]), 264'(0));
            for (int i = 0; i < 8; i++) begin
               check("post_rst_no_tv", 264'(tv_v[k]), 264'(0));
               tick;
            end
            model_reset();
            return;
         end
         if (mode == 1 && lat == 2) begin
            r = ~r_keep;
            s = rand128();
            first = 1'b1;
            ld_v[k] = 1'b1;
            key_ld_v[k] = 1'b1;
         end
         tick;
         ld_v[k] = 1'b0;
         key_ld_v[k] = 1'b0;
         r = r_keep;
      end
      check("latency", 264'(lat), 264'(exp_lat));
      check("tv_at_rdy", 264'(tv_v[k]), 264'(l));
      if (l) begin
         tag = 128'(131'(macc[k]) + 131'(ms[k]));
         macc[k] = '0;
         check("tag_model", 264'(p_v[k]), 264'(tag));
      end
   endtask

   task automatic run_vec1(input int k, input int mode_b2, input int mode_b3);
      run_block(k, 1'b1, 1'b0, 5'd16, M1, 0, 1'b0);
      if (k == 2) check("acc_blk1", 264'(g_dut[2].u_dut.acc), 264'(ACC1));
      run_block(k, 1'b0, 1'b0, 5'd16, M2, mode_b2, 1'b0);
      if (k == 2) check("acc_blk2", 264'(g_dut[2].u_dut.acc), 264'(ACC2));
      run_block(k, 1'b0, 1'b1, 5'd2, M3, mode_b3, 1'b0);
      if (mode_b3 == 0) check("vec1_tag", 264'(p_v[k]), 264'(TAG1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] t16, t0, t31, mr_len;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      key_ld_v = '0; ld_v = '0;
      r = '0; s = '0; m = '0; first = 1'b0; last = 1'b0; len = '0;
      model_reset();
      repeat (3) tick;
      check("reset_rdy", 264'(rdy_v), 264'(0));
      check("reset_tv", 264'(tv_v), 264'(0));
      check("reset_p", 264'(p_v[2]), 264'(0));
      check("reset_acc", 264'(g_dut[2].u_dut.acc), 264'(0));
      reset = 1'b0;
      tick;
      check("rdy_after_reset", 264'(rdy_v), 264'(5'h1f));

      // RFC 8439 vector with latency and single-cycle tag pulse.
      load_key(2, R1, S1);
      run_vec1(2, 0, 0);
      tick;
      check("tv_one_cycle", 264'(tv_v[2]), 264'(0));

      // Repeated messages: acc cleared by first, p holds between runs.
      for (int i = 0; i < 3; i++) run_vec1(2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("p_hold", 264'(p_v[2]), 264'(TAG1));
      end

      // Stray strobes mid-multiply are ignored.
      run_vec1(2, 1, 0);

      // Out-of-range lengths behave as 16.
      mr_len = rand128();
      run_block(2, 1'b1, 1'b1, 5'd16, mr_len, 0, 1'b0);
      t16 = p_v[2];
      run_block(2, 1'b1, 1'b1, 5'd0, mr_len, 0, 1'b0);
      t0 = p_v[2];
      run_block(2, 1'b1, 1'b1, 5'd31, mr_len, 0, 1'b0);
      t31 = p_v[2];
      check("len0_eq_len16", 264'(t0), 264'(t16));
      check("len31_eq_len16", 264'(t31), 264'(t16));

      // Reset during the last block aborts; a rerun recovers.
      run_vec1(2, 0, 2);
      load_key(2, R1, S1);
      run_vec1(2, 0, 0);

      // Other digit widths give the same tag with their own latencies.
      for (int k = 0; k < 5; k++) begin
         if (k != 2) begin
            load_key(k, R1, S1);
            run_vec1(k, 0, 0);
         end
      end

      // Random keys and messages; iteration 0 uses r=0, odd ones load the key with the first block.
      for (int it = 0; it < 24; it++) begin
         int           k;
         int           nb;
         logic [127:0] rr, ss;
         k  = $urandom_range(0, 4);
         rr = (it == 0) ? 128'(0) : rand128();
         ss = rand128();
         nb = $urandom_range(1, 4);
         if (it % 2 == 1) begin
            r = rr;
            s = ss;
         end else begin
            load_key(k, rr, ss);
         end
         for (int b = 0; b < nb; b++) begin
            run_block(k, 1'(b == 0), 1'(b == nb - 1), 5'($urandom_range(0, 31)), rand128(), 0,
                      1'((it % 2 == 1) && (b == 0)));
         end
         if (it == 0) check("r0_tag_is_s", 264'(p_v[k]), 264'(ss));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
